// File: rtl/atm_session_if.sv
// Front-panel / display bundle for the ATM session controller.
// master = panel + display side (testbench), slave = the controller.
interface atm_session_if #(
    parameter int NUM_CARDS       = 4,
    parameter int PASSWORD_SIZE   = 16,
    parameter int CREDIT_VAL_SIZE = 16,
    parameter int ATM_CAP_SIZE    = 20
);
    localparam int IW = $clog2(NUM_CARDS);

    logic                       atm_init;
    logic [ATM_CAP_SIZE-1:0]    atm_capacity;
    logic                       acct_wr;
    logic [IW-1:0]              acct_idx;
    logic [PASSWORD_SIZE-1:0]   acct_pin;
    logic [CREDIT_VAL_SIZE-1:0] acct_bal;
    logic                       insert;
    logic [IW:0]                input_card_pin;
    logic [PASSWORD_SIZE-1:0]   input_password;
    logic [1:0]                 op_choice;
    logic [CREDIT_VAL_SIZE-1:0] amount;
    logic [IW:0]                transfer_card_pin;
    logic                       enter;
    logic                       cancel;
    logic [CREDIT_VAL_SIZE-1:0] available_credit_out;
    logic                       done;
    logic                       abort;
    logic                       card_spell_out;
    logic                       card_retained;
    logic [2:0]                 current_state;

    modport master (
        output atm_init, atm_capacity, acct_wr, acct_idx, acct_pin, acct_bal,
               insert, input_card_pin, input_password, op_choice, amount,
               transfer_card_pin, enter, cancel,
        input  available_credit_out, done, abort, card_spell_out,
               card_retained, current_state
    );

    modport slave (
        input  atm_init, atm_capacity, acct_wr, acct_idx, acct_pin, acct_bal,
               insert, input_card_pin, input_password, op_choice, amount,
               transfer_card_pin, enter, cancel,
        output available_credit_out, done, abort, card_spell_out,
               card_retained, current_state
    );
endinterface

// File: rtl/atm_session_ctrl.sv
// Multi-account ATM session controller: card insert, PIN check with retry
// limit and retention, menu, one-cycle transaction execution, eject,
// inactivity timeout and machine cash tracking.
// ATM_CAP_SIZE is assumed to be >= CREDIT_VAL_SIZE.
module atm_session_ctrl #(
    parameter int NUM_CARDS       = 4,
    parameter int PASSWORD_SIZE   = 16,
    parameter int CREDIT_VAL_SIZE = 16,
    parameter int ATM_CAP_SIZE    = 20,
    parameter int MAX_TRIES       = 3,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic          clk,
    input  logic          rst,
    atm_session_if.slave  bus
);
    localparam int IW  = $clog2(NUM_CARDS);
    localparam int TW  = $clog2(MAX_TRIES + 1);
    localparam int CW  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW  = PASSWORD_SIZE;
    localparam int VW  = CREDIT_VAL_SIZE;
    localparam int AW  = ATM_CAP_SIZE;
    localparam logic [IW:0] CARD_LIMIT = (IW + 1)'(NUM_CARDS);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PIN   = 3'd1,
        S_MENU  = 3'd2,
        S_EXEC  = 3'd3,
        S_EJECT = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   card_q, card_d;
    logic [TW-1:0]   tries_q, tries_d;
    logic [CW-1:0]   idle_q, idle_d;
    logic [1:0]      op_q, op_d;
    logic [VW-1:0]   amt_q, amt_d;
    logic [IW:0]     dst_q, dst_d;
    logic [AW-1:0]   cash_q, cash_d;
    logic [PW-1:0]   pin_q [NUM_CARDS];
    logic [PW-1:0]   pin_d [NUM_CARDS];
    logic [VW-1:0]   bal_q [NUM_CARDS];
    logic [VW-1:0]   bal_d [NUM_CARDS];
    logic [VW-1:0]   avail_q, avail_d;
    logic            done_q, done_d;
    logic            abort_q, abort_d;
    logic            spell_q, spell_d;
    logic            retained_q, retained_d;

    // Operand views used by the EXEC checks; the extra top bit of each sum
    // is the overflow flag.
    logic [IW-1:0]   dst_idx;
    logic [VW-1:0]   src_bal;
    logic [VW-1:0]   dst_bal;
    logic [AW-1:0]   amt_cash;
    logic [VW:0]     dep_bal_sum;
    logic [AW:0]     dep_cash_sum;
    logic [VW:0]     xfer_sum;
    logic            dst_valid;
    logic            timeout;

    assign dst_idx      = dst_q[IW-1:0];
    assign src_bal      = bal_q[card_q];
    assign dst_bal      = bal_q[dst_idx];
    assign amt_cash     = AW'(amt_q);
    assign dep_bal_sum  = {1'b0, src_bal} + {1'b0, amt_q};
    assign dep_cash_sum = {1'b0, cash_q} + {1'b0, amt_cash};
    assign xfer_sum     = {1'b0, dst_bal} + {1'b0, amt_q};
    assign dst_valid    = (dst_q < CARD_LIMIT) && (dst_idx != card_q);
    assign timeout      = (idle_q == CW'(TIMEOUT_CYCLES - 1));

    // Next-state, datapath updates and registered pulse outputs.
    always_comb begin
        state_d    = state_q;
        card_d     = card_q;
        tries_d    = tries_q;
        idle_d     = idle_q;
        op_d       = op_q;
        amt_d      = amt_q;
        dst_d      = dst_q;
        cash_d     = cash_q;
        pin_d      = pin_q;
        bal_d      = bal_q;
        avail_d    = avail_q;
        done_d     = 1'b0;
        abort_d    = 1'b0;
        spell_d    = 1'b0;
        retained_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.acct_wr) begin
                    pin_d[bus.acct_idx] = bus.acct_pin;
                    bal_d[bus.acct_idx] = bus.acct_bal;
                end
                if (bus.insert) begin
                    if (bus.input_card_pin < CARD_LIMIT) begin
                        card_d  = bus.input_card_pin[IW-1:0];
                        tries_d = '0;
                        state_d = S_PIN;
                    end else begin
                        // Unknown card: reject and hand it straight back.
                        abort_d = 1'b1;
                        spell_d = 1'b1;
                    end
                end
            end
            S_PIN: begin
                if (bus.cancel) begin
                    abort_d = 1'b1;
                    state_d = S_EJECT;
                end else if (bus.enter) begin
                    if (bus.input_password == pin_q[card_q]) begin
                        state_d = S_MENU;
                    end else if (tries_q == TW'(MAX_TRIES - 1)) begin
                        // Last allowed attempt failed: keep the card.
                        retained_d = 1'b1;
                        tries_d    = '0;
                        state_d    = S_IDLE;
                    end else begin
                        tries_d = tries_q + TW'(1);
                        abort_d = 1'b1;
                    end
                end else if (timeout) begin
                    abort_d = 1'b1;
                    state_d = S_EJECT;
                end
            end
            S_MENU: begin
                if (bus.cancel) begin
                    abort_d = 1'b1;
                    state_d = S_EJECT;
                end else if (bus.enter) begin
                    op_d    = bus.op_choice;
                    amt_d   = bus.amount;
                    dst_d   = bus.transfer_card_pin;
                    state_d = S_EXEC;
                end else if (timeout) begin
                    abort_d = 1'b1;
                    state_d = S_EJECT;
                end
            end
            S_EXEC: begin
                state_d = S_MENU;
                case (op_q)
                    2'd0: begin
                        done_d  = 1'b1;
                        avail_d = src_bal;
                    end
                    2'd1: begin
                        if (dep_bal_sum[VW] || dep_cash_sum[AW]) begin
                            abort_d = 1'b1;
                        end else begin
                            bal_d[card_q] = dep_bal_sum[VW-1:0];
                            cash_d        = dep_cash_sum[AW-1:0];
                            avail_d       = dep_bal_sum[VW-1:0];
                            done_d        = 1'b1;
                        end
                    end
                    2'd2: begin
                        if ((amt_q > src_bal) || (amt_cash > cash_q) || (amt_q == '0)) begin
                            abort_d = 1'b1;
                        end else begin
                            bal_d[card_q] = src_bal - amt_q;
                            cash_d        = cash_q - amt_cash;
                            avail_d       = src_bal - amt_q;
                            done_d        = 1'b1;
                        end
                    end
                    2'd3: begin
                        if (!dst_valid || (amt_q > src_bal) || xfer_sum[VW]) begin
                            abort_d = 1'b1;
                        end else begin
                            bal_d[card_q]  = src_bal - amt_q;
                            bal_d[dst_idx] = xfer_sum[VW-1:0];
                            avail_d        = src_bal - amt_q;
                            done_d         = 1'b1;
                        end
                    end
                endcase
            end
            S_EJECT: begin
                spell_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Operator reload of the cash register overrides any EXEC update.
        if (bus.atm_init) begin
            cash_d = bus.atm_capacity;
        end

        // Inactivity counter: any operator action or state move restarts it.
        if (bus.enter || bus.cancel || (state_d != state_q)) begin
            idle_d = '0;
        end else if ((state_q == S_PIN) || (state_q == S_MENU)) begin
            idle_d = idle_q + CW'(1);
        end
    end

    // State and datapath registers; reset wipes accounts and cash too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            card_q     <= '0;
            tries_q    <= '0;
            idle_q     <= '0;
            op_q       <= '0;
            amt_q      <= '0;
            dst_q      <= '0;
            cash_q     <= '0;
            avail_q    <= '0;
            done_q     <= 1'b0;
            abort_q    <= 1'b0;
            spell_q    <= 1'b0;
            retained_q <= 1'b0;
            for (int i = 0; i < NUM_CARDS; i++) begin
                pin_q[i] <= '0;
                bal_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            card_q     <= card_d;
            tries_q    <= tries_d;
            idle_q     <= idle_d;
            op_q       <= op_d;
            amt_q      <= amt_d;
            dst_q      <= dst_d;
            cash_q     <= cash_d;
            avail_q    <= avail_d;
            done_q     <= done_d;
            abort_q    <= abort_d;
            spell_q    <= spell_d;
            retained_q <= retained_d;
            pin_q      <= pin_d;
            bal_q      <= bal_d;
        end
    end

    assign bus.available_credit_out = avail_q;
    assign bus.done                 = done_q;
    assign bus.abort                = abort_q;
    assign bus.card_spell_out       = spell_q;
    assign bus.card_retained        = retained_q;
    assign bus.current_state        = state_q;
endmodule
